// File: rtl/transmitter_core.sv
// Serial byte transmitter: start bit, 8 data bits LSB first, odd parity, stop bit.
// The start bit appears 1 clk after send is accepted in IDLE. A send that arrives while busy is dropped, and nothing is queued.
module transmitter_core #(
  parameter int CLK_RATE  = 100_000_000,
  parameter int BAUD_RATE = 19200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  // Bit period rounded down to a multiple of 16 so it matches a 16x-oversampled receiver.
  localparam int BIT_CYCLES = 16 * (CLK_RATE / BAUD_RATE / 16);
  localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [TW-1:0] TC = TW'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic [2:0]    idx, idx_d;
  logic [7:0]    shift, shift_d;
  logic          par, par_d;
  logic          tx_d, busy_d, done_d;
  logic          tc;

  assign tc = (timer == TC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      idx     <= '0;
      shift   <= '0;
      par     <= 1'b0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_d;
      timer   <= timer_d;
      idx     <= idx_d;
      shift   <= shift_d;
      par     <= par_d;
      tx      <= tx_d;
      tx_busy <= busy_d;
      tx_done <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    timer_d = timer;
    idx_d   = idx;
    shift_d = shift;
    par_d   = par;
    if (state != IDLE)
      timer_d = tc ? '0 : timer + 1'b1;
    case (state)
      IDLE: begin
        if (send) begin
          state_d = START;
          shift_d = din;
          par_d   = ~^din;
          timer_d = '0;
          idx_d   = '0;
        end
      end
      START:  if (tc) state_d = DATA;
      DATA: begin
        if (tc) begin
          shift_d = {1'b0, shift[7:1]};
          idx_d   = idx + 3'd1;
          if (idx == 3'd7)
            state_d = PARITY;
        end
      end
      PARITY: if (tc) state_d = STOP;
      STOP:   if (tc) state_d = IDLE;
      default: begin
        state_d = IDLE;
        timer_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so tx and tx_busy come straight from flops.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state == STOP) && tc;
  end

endmodule

// File: tb/tb_transmitter_core.sv
// Scoreboard bench: acceptance model pushes expected bytes, a bit-center receiver monitor pops and checks.
`timescale 1ns/1ps
module tb_transmitter_core;

  localparam int CLK_RATE  = 1_600_000;
  localparam int BAUD_RATE = 10_000;
  localparam int BC        = 160;
  localparam int FRAME     = 11 * BC;

  logic       clk = 1'b0;
  logic       rst;
  logic       send;
  logic [7:0] din;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  transmitter_core #(.CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD_RATE)) dut (
    .clk     (clk),
    .rst     (rst),
    .send    (send),
    .din     (din),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input bit ok, input string name, input int act, input int exp_v);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp_v);
    end
  endtask

  // Acceptance model: a send is taken only when no frame is outstanding.
  int         cyc       = 0;
  int         remaining = 0;
  int         accepted  = 0;
  bit         rst_chk   = 0;
  logic [7:0] exp_q[$];
  int         acc_q[$];

  always @(posedge clk) begin
    cyc++;
    if (rst === 1'b1) begin
      remaining = 0;
      rst_chk   = 1;
    end else if (remaining == 0) begin
      if (send === 1'b1) begin
        exp_q.push_back(din);
        acc_q.push_back(cyc);
        accepted++;
        remaining = FRAME;
      end
    end else begin
      remaining--;
    end
  end

  // Receiver monitor: every bit must hold its expected level for all BC cycles.
  bit          mon_active = 0;
  bit          done_chk   = 0;
  int          mon_bit, mon_cnt, mon_bad, mon_busy_drop, acc_cyc;
  int          spurious_done = 0;
  logic [10:0] exp_bits, rx_bits;
  logic [7:0]  exp_byte;

  always @(negedge clk) begin
    if (rst_chk) begin
      rst_chk = 0;
      check(tx === 1'b1 && tx_busy === 1'b0 && tx_done === 1'b0, "reset_outputs",
            {tx, tx_busy, tx_done}, 3'b100);
      mon_active = 0;
      done_chk   = 0;
    end else if (done_chk) begin
      done_chk = 0;
      check(tx_done === 1'b1 && tx_busy === 1'b0 && tx === 1'b1, "done_pulse",
            {tx, tx_busy, tx_done}, 3'b101);
    end else begin
      if (tx_done !== 1'b0) spurious_done++;
      if (!mon_active && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_frame", 1, 0);
          exp_byte = 8'h00;
        end else begin
          exp_byte = exp_q.pop_front();
          acc_cyc  = acc_q.pop_front();
          check(cyc == acc_cyc, "start_latency", cyc - acc_cyc, 0);
        end
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = exp_byte[i];
        exp_bits[9]  = ($countones(exp_byte) % 2 == 0) ? 1'b1 : 1'b0;
        exp_bits[10] = 1'b1;
        mon_active    = 1;
        mon_bit       = 0;
        mon_cnt       = 0;
        mon_bad       = 0;
        mon_busy_drop = 0;
      end
      if (mon_active) begin
        if (tx !== exp_bits[mon_bit]) mon_bad++;
        if (tx_busy !== 1'b1) mon_busy_drop++;
        if (mon_cnt == BC / 2) rx_bits[mon_bit] = tx;
        mon_cnt++;
        if (mon_cnt == BC) begin
          check(mon_bad == 0, $sformatf("bit%0d_level_width", mon_bit), mon_bad, 0);
          mon_bad = 0;
          mon_cnt = 0;
          mon_bit++;
          if (mon_bit == 11) begin
            mon_active = 0;
            done_chk   = 1;
            check(rx_bits[8:1] === exp_byte, "rx_byte", rx_bits[8:1], exp_byte);
            check(rx_bits[0] === 1'b0 && rx_bits[10] === 1'b1 && ($countones(rx_bits[9:1]) % 2 == 1),
                  "rx_parity_framing", rx_bits, {1'b1, ~^exp_byte, exp_byte, 1'b0});
            check(mon_busy_drop == 0, "busy_continuous", mon_busy_drop, 0);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    din  = b;
    send = 1'b1;
    tick();
    send = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((tx_busy !== 1'b0 || mon_active || done_chk) && n < 3 * FRAME) begin
      tick();
      n++;
    end
    check(n < 3 * FRAME, "idle_timeout", n, 3 * FRAME);
    tick();
    tick();
  endtask

  initial begin
    logic [7:0] directed [4];
    int         base, n;
    directed = '{8'h55, 8'h01, 8'h00, 8'hFF};
    rst  = 1'b1;
    send = 1'b0;
    din  = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    foreach (directed[i]) begin
      send_byte(directed[i]);
      wait_idle();
    end

    // Mid-frame send and din change must not disturb the frame.
    send_byte(8'h96);
    repeat (499) tick();
    din  = 8'hAA;
    send = 1'b1;
    tick();
    send = 1'b0;
    din  = 8'h11;
    wait_idle();

    // Send held high: two frames with a single idle-high cycle between them.
    base = accepted;
    din  = 8'h3C;
    send = 1'b1;
    repeat (300) tick();
    din = 8'hC3;
    n = 0;
    while (accepted < base + 2 && n < 2 * FRAME) begin
      tick();
      n++;
    end
    check(accepted == base + 2, "b2b_accept", accepted - base, 2);
    send = 1'b0;
    wait_idle();

    // Reset mid-frame aborts, then a fresh frame is clean.
    send_byte(8'hF0);
    repeat (799) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check(tx_busy === 1'b0 && tx === 1'b1, "abort_stays_idle", {tx, tx_busy}, 2'b10);
    send_byte(8'h0F);
    wait_idle();

    // Reset wins over a simultaneous send.
    rst  = 1'b1;
    send = 1'b1;
    din  = 8'hA5;
    tick();
    rst  = 1'b0;
    send = 1'b0;
    repeat (3) tick();
    check(tx_busy === 1'b0 && tx === 1'b1, "rst_beats_send", {tx, tx_busy}, 2'b10);

    for (int k = 0; k < 15; k++) begin
      send_byte(8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 1500)) tick();
        din  = 8'($urandom);
        send = 1'b1;
        tick();
        send = 1'b0;
      end
      wait_idle();
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (5) tick();
    check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    check(spurious_done == 0, "spurious_done", spurious_done, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
